// File: rtl/ring_slot_sched.sv
// Round-robin time-slot scheduler: one-hot rotating priority token plus a
// slot FSM that grants, times and releases one requester at a time.
module ring_slot_sched #(
  parameter int unsigned N        = 4,
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          mrst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  input  logic          load,
  input  logic [IW-1:0] start_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          busy,
  output logic          slot_start,
  output logic          err
);

  localparam int unsigned CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned SW = IW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [N-1:0] TOK_RST = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    state, state_nxt;
  logic [N-1:0]  token, token_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] grant_idx_nxt;
  logic          slot_start_nxt;
  logic          err_nxt;

  logic [IW-1:0] tok_pos;
  logic [N-1:0]  rot;
  logic          sel_found;
  logic [SW-1:0] sel_sum;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  sel_vec;
  logic          load_ok;
  logic [N-1:0]  load_vec;
  logic          release_now;

  // Token position and round-robin pick: rotate req so the token sits at bit 0.
  always_comb begin
    tok_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (token[i]) tok_pos = IW'(i);
    end
    rot = (req >> tok_pos) | (req << (SW'(N) - SW'(tok_pos)));
    sel_found = 1'b0;
    sel_sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && rot[k]) begin
        sel_found = 1'b1;
        sel_sum   = SW'(tok_pos) + SW'(k);
      end
    end
    if (32'(sel_sum) >= N) sel_idx = IW'(sel_sum - SW'(N));
    else                   sel_idx = IW'(sel_sum);
    sel_vec = '0;
    for (int i = 0; i < N; i++) begin
      sel_vec[i] = (sel_idx == IW'(i));
    end
  end

  // Preload decode and slot release condition.
  always_comb begin
    load_ok  = (32'(start_idx) < N);
    load_vec = '0;
    for (int i = 0; i < N; i++) begin
      load_vec[i] = (start_idx == IW'(i));
    end
    release_now = (cnt == '0) || (|(done & grant)) || !(|(req & grant));
  end

  // Slot FSM next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    token_nxt      = token;
    cnt_nxt        = cnt;
    grant_nxt      = grant;
    grant_idx_nxt  = grant_idx;
    slot_start_nxt = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (load) begin
          if (load_ok) token_nxt = load_vec;
          else         err_nxt   = 1'b1;
        end else if (en && sel_found) begin
          token_nxt      = sel_vec;
          grant_nxt      = sel_vec;
          grant_idx_nxt  = sel_idx;
          cnt_nxt        = CW'(SLOT_LEN - 1);
          slot_start_nxt = 1'b1;
          state_nxt      = HOLD;
        end
      end
      HOLD: begin
        if (release_now) begin
          grant_nxt = '0;
          token_nxt = {token[N-2:0], token[N-1]};
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge mrst) begin
    if (!mrst) begin
      state      <= IDLE;
      token      <= TOK_RST;
      cnt        <= '0;
      grant      <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      slot_start <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      token      <= token_nxt;
      cnt        <= cnt_nxt;
      grant      <= grant_nxt;
      grant_idx  <= grant_idx_nxt;
      busy       <= (state_nxt != IDLE);
      slot_start <= slot_start_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ring_slot_sched.sv
// Self-checking bench for ring_slot_sched: directed table, corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_ring_slot_sched;

  localparam int N  = 4;
  localparam int SL = 4;
  localparam int IW = 3;

  logic          clk;
  logic          mrst;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic          load;
  logic [IW-1:0] start_idx;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic          slot_start;
  logic          err;

  ring_slot_sched #(.N(N), .SLOT_LEN(SL), .IW(IW)) dut (
    .clk(clk), .mrst(mrst), .en(en), .req(req), .done(done), .load(load),
    .start_idx(start_idx), .grant(grant), .grant_idx(grant_idx), .busy(busy),
    .slot_start(slot_start), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase 0 idle, 1 granted, 2 dead cycle.
  int m_phase, m_pos, m_g, m_used, m_idx;
  bit m_ss, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_g = 0; m_used = 0; m_idx = 0; m_ss = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_ss = 0; m_err = 0;
    case (m_phase)
      0: begin
        if (load) begin
          if (int'(start_idx) < N) m_pos = int'(start_idx);
          else m_err = 1;
        end else if (en && req != 0) begin
          for (int k = 0; k < N; k++) begin
            if (m_phase == 0 && req[(m_pos + k) % N]) begin
              m_g = (m_pos + k) % N;
              m_pos = m_g; m_idx = m_g; m_used = 1; m_ss = 1; m_phase = 1;
            end
          end
        end
      end
      1: begin
        if (m_used >= SL || done[m_g] || !req[m_g]) begin
          m_phase = 2;
          m_pos = (m_pos + 1) % N;
        end else begin
          m_used++;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [31:0] model_vec();
    logic [N-1:0] g;
    g = (m_phase == 1) ? N'(1) << m_g : '0;
    return 32'({g, IW'(m_idx), m_phase != 0, m_ss, m_err});
  endfunction

  // One clock: update the model at the edge, compare shortly after.
  task automatic step();
    @(posedge clk);
    if (!mrst) model_reset();
    else model_edge();
    #1;
    chk("model", 32'({grant, grant_idx, busy, slot_start, err}), model_vec());
  endtask

  task automatic do_reset();
    @(negedge clk);
    mrst = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 32'({grant, grant_idx, busy, slot_start, err}), 32'd0);
    @(negedge clk);
    mrst = 1'b1;
  endtask

  typedef struct {
    logic ld; logic [IW-1:0] si; logic en; logic [N-1:0] rq; logic [N-1:0] dn;
    logic [N-1:0] g; logic [IW-1:0] gi; logic b; logic ss; logic er;
  } vec_t;
  vec_t tbl[24];

  task automatic put(input int i, input logic ld, input logic [IW-1:0] si, input logic e,
                     input logic [N-1:0] rq, input logic [N-1:0] dn, input logic [N-1:0] g,
                     input logic [IW-1:0] gi, input logic b, input logic ss, input logic er);
    tbl[i].ld = ld; tbl[i].si = si; tbl[i].en = e; tbl[i].rq = rq; tbl[i].dn = dn;
    tbl[i].g = g; tbl[i].gi = gi; tbl[i].b = b; tbl[i].ss = ss; tbl[i].er = er;
  endtask

  int hi;

  initial begin
    mrst = 1'b0; en = 1'b0; req = '0; done = '0; load = 1'b0; start_idx = '0;
    model_reset();

    // Continuous load rotation, preload, early done and illegal preload.
    put(0, 0, 0, 1, 4'hf, 0, 4'b0001, 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++) put(i, 0, 0, 1, 4'hf, 0, 4'b0001, 0, 1, 0, 0);
    put(4, 0, 0, 1, 4'hf, 0, 4'b0000, 0, 1, 0, 0);
    put(5, 0, 0, 1, 4'hf, 0, 4'b0000, 0, 0, 0, 0);
    put(6, 0, 0, 1, 4'hf, 0, 4'b0010, 1, 1, 1, 0);
    for (int i = 7; i <= 9; i++) put(i, 0, 0, 1, 4'hf, 0, 4'b0010, 1, 1, 0, 0);
    put(10, 0, 0, 1, 4'hf, 0, 4'b0000, 1, 1, 0, 0);
    put(11, 0, 0, 1, 4'hf, 0, 4'b0000, 1, 0, 0, 0);
    put(12, 0, 0, 1, 4'hf, 0, 4'b0100, 2, 1, 1, 0);
    for (int i = 13; i <= 15; i++) put(i, 0, 0, 1, 4'hf, 0, 4'b0100, 2, 1, 0, 0);
    put(16, 0, 0, 1, 4'hf, 0, 4'b0000, 2, 1, 0, 0);
    put(17, 0, 0, 1, 4'hf, 0, 4'b0000, 2, 0, 0, 0);
    put(18, 1, 2, 1, 4'hf, 0, 4'b0000, 2, 0, 0, 0);
    put(19, 0, 0, 1, 4'hf, 0, 4'b0100, 2, 1, 1, 0);
    put(20, 0, 0, 1, 4'hf, 4'b0100, 4'b0000, 2, 1, 0, 0);
    put(21, 0, 0, 1, 4'hf, 0, 4'b0000, 2, 0, 0, 0);
    put(22, 1, 6, 1, 4'hf, 0, 4'b0000, 2, 0, 0, 1);
    put(23, 0, 0, 1, 4'hf, 0, 4'b1000, 3, 1, 1, 0);

    do_reset();
    for (int i = 0; i < 24; i++) begin
      load = tbl[i].ld; start_idx = tbl[i].si; en = tbl[i].en;
      req = tbl[i].rq; done = tbl[i].dn;
      step();
      chk($sformatf("tbl%0d", i), 32'({grant, grant_idx, busy, slot_start, err}),
          32'({tbl[i].g, tbl[i].gi, tbl[i].b, tbl[i].ss, tbl[i].er}));
    end
    load = 1'b0; start_idx = '0; done = '0;

    // Asynchronous reset in the middle of a slot.
    #2 mrst = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    mrst = 1'b1;
    req = 4'hf; en = 1'b1;
    step();
    chk("post_rst_grant", 32'(grant), 32'b0001);

    // Single requester, then wrap from bit 3 back to bit 0.
    do_reset();
    req = 4'b0100; en = 1'b1;
    step();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_idx", 32'(grant_idx), 32'd2);
    repeat (3) step();
    step();
    chk("single_rel", 32'({grant, busy}), 32'({4'b0000, 1'b1}));
    req = 4'b0011;
    step();
    step();
    chk("wrap_grant", 32'(grant), 32'b0001);
    chk("wrap_idx", 32'(grant_idx), 32'd0);

    // Request withdrawn mid-slot, then early done in the second cycle.
    req = 4'b0010;
    step();
    chk("req_drop", 32'({grant, busy}), 32'({4'b0000, 1'b1}));
    step();
    step();
    chk("done_c1", 32'(grant), 32'b0010);
    step();
    chk("done_c2", 32'(grant), 32'b0010);
    done = 4'b0010;
    step();
    chk("done_rel", 32'(grant), 32'd0);
    done = '0;

    // Enable drop during a slot: slot completes, nothing new until en returns.
    req = 4'hf;
    step();
    step();
    chk("en_grant", 32'(grant), 32'b0100);
    en = 1'b0;
    hi = 0;
    repeat (8) begin
      step();
      if (grant != 0) hi++;
    end
    chk("en_low_len", 32'(hi), 32'd3);
    chk("en_low_idle", 32'({grant, busy}), 32'd0);
    en = 1'b1;
    step();
    chk("en_back", 32'({grant, slot_start}), 32'({4'b1000, 1'b1}));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      mrst = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      load = ($urandom_range(0, 19) == 0);
      start_idx = IW'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
